data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port 256x8 byte-addressed data memory between two requesters.
//  Port A is the processor load/store path; port B is the text loader/DMA.
//  - Round-robin arbitration, with an optional locked burst per requester.
//  - Drives the memory's we/address/wdata and returns registered read data per port.
//  - Sits between the core datapath and dataMemory.
// PARAMETERS
//  MAX_BURST    8  max consecutive grants to one locked owner before forced release (1..255)
//  ALIGN_CHECK  1  1: reject word accesses with addr[1:0]!=0; 0: pass any byte address
// PORTS
//  clk           in   1   system clock; all state updates on posedge
//  rst           in   1   synchronous, active-high reset
//  {a,b}_req     in   1   access request; held with fields stable until gnt
//  {a,b}_we      in   1   1 = word write, 0 = word read
//  {a,b}_lock    in   1   request exclusive ownership for following accesses
//  {a,b}_addr    in   8   byte address of word MSB byte
//  {a,b}_wdata   in   32  write data
//  {a,b}_gnt     out  1   access performed this cycle (combinational)
//  {a,b}_rvalid  out  1   read data valid, one cycle after read grant
//  {a,b}_rdata   out  32  registered read data; holds until next read of that port
//  {a,b}_err     out  1   one-cycle pulse: misaligned access rejected
//  mem_we        out  1   to memory write enable (memory commits on negedge)
//  mem_addr      out  8   to memory address
//  mem_wdata     out  32  to memory write data
//  mem_rdata     in   32  from memory, combinational read of mem_addr
// BEHAVIOUR
//  Reset and gnt rules
//  - Reset: state=IDLE, rr_last=B, burst_cnt=0, rvalid/err/rdata=0.
//  - Reset mid-burst drops ownership and suppresses any pending rvalid/err.
//  - At most one gnt per cycle. Ungranted mem_we=0, mem_addr=0, mem_wdata=0.
//  State machine: IDLE, OWN_A, OWN_B
//  - IDLE, one req: grant it.
//  - IDLE, both req: grant the port != rr_last (first tie after reset -> A).
//    rr_last <= winner.
//  - IDLE, granted port has lock=1: next OWN_X, burst_cnt <= 1; else stay IDLE.
//  - OWN_X: only X may be granted; other port stalls (gnt=0) regardless of req.
//    On each X grant, burst_cnt++.
//  - OWN_X -> IDLE when any of:
//    - X grant with lock=0 (that access still served);
//    - X req=0 for a cycle;
//    - X grant with burst_cnt==MAX_BURST (forced release).
//    rr_last=X so the other port wins the next tie.
//  Access path
//  - Granted cycle: mem_addr=x_addr, mem_wdata=x_wdata, mem_we=x_we & !misaligned.
//  - Read: at posedge closing the grant cycle, x_rdata<=mem_rdata and x_rvalid<=1
//    for one cycle. Latency = 1.
//  - Write: gnt is completion; no rvalid.
//  - Misaligned (ALIGN_CHECK=1, addr[1:0]!=0): gnt=1 (request consumed),
//    mem_we=0, x_err pulses next cycle, no rvalid.
//  - ALIGN_CHECK=0: addr 253..255 passed unchanged; memory wraps bytes modulo 256.
//  - Back-to-back grants to the same port allowed every cycle; throughput 1 word/cycle.
// TESTING
//  - Reset, then A write addr 0x10 data 0xDEADBEEF, then A read 0x10
//    -> a_gnt each cycle, a_rvalid 1 cycle later, a_rdata=0xDEADBEEF.
//  - A and B both read in same cycle after reset
//    -> A granted first, B granted next cycle.
//    Repeat tie -> order alternates B, A.
//  - B lock=1, 10 back-to-back reads, MAX_BURST=8, A requesting throughout
//    -> B gets 8 grants, then A granted, then B resumes.
//  - A read addr 0x05, ALIGN_CHECK=1 -> a_gnt=1, mem_we=0, a_err pulse, no a_rvalid.
//    Memory unchanged.
//  - rst asserted during B locked burst
//    -> next cycle state IDLE, all outputs 0; pending b_rvalid never asserts.
//  - ALIGN_CHECK=0, A write 0x11223344 at 0xFE, read 0xFE
//    -> a_rdata=0x11223344; byte 0x00 holds 0x33.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port 256x8 data memory between the load/store path (A)
// and the text loader/DMA (B): round-robin on ties, optional locked bursts.
module data_mem_arbiter #(
    parameter int unsigned MAX_BURST   = 8,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic        a_lock,
    input  logic [7:0]  a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_we,
    input  logic        b_lock,
    input  logic [7:0]  b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_e;
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST);

    state_e      state_q, state_d;
    port_e       rr_last_q, rr_last_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic        a_rvalid_q, b_rvalid_q, a_err_q, b_err_q;
    logic [31:0] a_rdata_q, b_rdata_q;

    logic        a_mis, b_mis, a_rd, b_rd;
    logic        own_req, own_lock, burst_last;
    port_e       owner;

    assign a_mis = ALIGN_CHECK && (a_addr[1:0] != 2'b00);
    assign b_mis = ALIGN_CHECK && (b_addr[1:0] != 2'b00);
    assign a_rd  = a_gnt && !a_we && !a_mis;
    assign b_rd  = b_gnt && !b_we && !b_mis;

    assign owner      = (state_q == OWN_B) ? PORT_B : PORT_A;
    assign own_req    = (owner == PORT_B) ? b_req  : a_req;
    assign own_lock   = (owner == PORT_B) ? b_lock : a_lock;
    assign burst_last = ({1'b0, burst_cnt_q} + 9'd1) == BURST_LIMIT;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_req && b_req) begin
                    a_gnt = (rr_last_q == PORT_B);
                    b_gnt = (rr_last_q == PORT_A);
                end else begin
                    a_gnt = a_req;
                    b_gnt = b_req;
                end
            end
            OWN_A:   a_gnt = a_req;
            OWN_B:   b_gnt = b_req;
            default: ;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (a_gnt) begin
            mem_we    = a_we && !a_mis;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_we    = b_we && !b_mis;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (a_req && b_req) begin
                    rr_last_d = a_gnt ? PORT_A : PORT_B;
                end
                // With a burst limit of one, a locked grant is just a plain access.
                if (BURST_LIMIT > 9'd1) begin
                    if (a_gnt && a_lock) begin
                        state_d     = OWN_A;
                        burst_cnt_d = 8'd1;
                    end else if (b_gnt && b_lock) begin
                        state_d     = OWN_B;
                        burst_cnt_d = 8'd1;
                    end
                end
            end
            OWN_A, OWN_B: begin
                // Count includes the current grant, so release fires on grant MAX_BURST.
                if (!own_req || !own_lock || burst_last) begin
                    state_d     = IDLE;
                    rr_last_d   = owner;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_last_q   <= PORT_B;
            burst_cnt_q <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_err_q     <= 1'b0;
            b_err_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            burst_cnt_q <= burst_cnt_d;
            a_rvalid_q  <= a_rd;
            b_rvalid_q  <= b_rd;
            a_err_q     <= a_gnt && a_mis;
            b_err_q     <= b_gnt && b_mis;
            if (a_rd) a_rdata_q <= mem_rdata;
            if (b_rd) b_rdata_q <= mem_rdata;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_err    = a_err_q;
    assign b_err    = b_err_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed scenarios plus random traffic
// against a byte-array memory model; a second instance covers ALIGN_CHECK=0.
module tb_data_mem_arbiter;
    localparam int unsigned MAXB = 8;
    localparam logic [1:0] K_NONE = 2'd0, K_READ = 2'd1, K_ERR = 2'd2, K_RST = 2'd3;

    typedef struct packed {
        logic        req;
        logic        we;
        logic        lock;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
    logic [7:0]  a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic        b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
    logic [7:0]  b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_we;
    logic [7:0]  mem_addr, ma1, ma2, ma3;
    logic [31:0] mem_wdata, mem_rdata;

    logic        u_rst = 1'b1;
    logic        u_a_req = 1'b0, u_a_we = 1'b0;
    logic [7:0]  u_a_addr = '0;
    logic [31:0] u_a_wdata = '0;
    logic        u_a_gnt, u_a_rvalid, u_a_err, u_b_gnt, u_b_rvalid, u_b_err;
    logic [31:0] u_a_rdata, u_b_rdata;
    logic        u_mem_we;
    logic [7:0]  u_mem_addr, u1, u2, u3;
    logic [31:0] u_mem_wdata, u_mem_rdata;

    data_mem_arbiter #(.MAX_BURST(MAXB), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    data_mem_arbiter #(.MAX_BURST(MAXB), .ALIGN_CHECK(1'b0)) dut0 (
        .clk(clk), .rst(u_rst),
        .a_req(u_a_req), .a_we(u_a_we), .a_lock(1'b0), .a_addr(u_a_addr), .a_wdata(u_a_wdata),
        .a_gnt(u_a_gnt), .a_rvalid(u_a_rvalid), .a_rdata(u_a_rdata), .a_err(u_a_err),
        .b_req(1'b0), .b_we(1'b0), .b_lock(1'b0), .b_addr(8'h00), .b_wdata(32'h0),
        .b_gnt(u_b_gnt), .b_rvalid(u_b_rvalid), .b_rdata(u_b_rdata), .b_err(u_b_err),
        .mem_we(u_mem_we), .mem_addr(u_mem_addr), .mem_wdata(u_mem_wdata),
        .mem_rdata(u_mem_rdata)
    );

    // Byte-addressed big-endian memories, writes on negedge, addresses wrap mod 256.
    logic [7:0] mem [256];
    logic [7:0] mem0 [256];
    logic [7:0] ref_mem [256];
    logic       load = 1'b0;

    assign ma1 = mem_addr + 8'd1;
    assign ma2 = mem_addr + 8'd2;
    assign ma3 = mem_addr + 8'd3;
    assign mem_rdata = {mem[mem_addr], mem[ma1], mem[ma2], mem[ma3]};
    assign u1 = u_mem_addr + 8'd1;
    assign u2 = u_mem_addr + 8'd2;
    assign u3 = u_mem_addr + 8'd3;
    assign u_mem_rdata = {mem0[u_mem_addr], mem0[u1], mem0[u2], mem0[u3]};

    always @(negedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]  <= ref_mem[i];
                mem0[i] <= 8'h00;
            end
        end else begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata[31:24];
                mem[ma1]      <= mem_wdata[23:16];
                mem[ma2]      <= mem_wdata[15:8];
                mem[ma3]      <= mem_wdata[7:0];
            end
            if (u_mem_we) begin
                mem0[u_mem_addr] <= u_mem_wdata[31:24];
                mem0[u1]         <= u_mem_wdata[23:16];
                mem0[u2]         <= u_mem_wdata[15:8];
                mem0[u3]         <= u_mem_wdata[7:0];
            end
        end
    end

    int unsigned checks = 0;
    int unsigned passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: one queue of expected registered responses per port.
    item_t       q [2][$];
    logic [31:0] held [2];
    logic        mon_en = 1'b0;

    task automatic mon_port(input int p, input string pn, input logic rv, input logic er,
                            input logic [31:0] rd);
        item_t it;
        it = '0;
        if (q[p].size() > 0) it = q[p].pop_front();
        if (it.kind == K_READ) held[p] = it.data;
        else if (it.kind == K_RST) held[p] = '0;
        chk({pn, "_rvalid"}, {31'd0, rv}, {31'd0, it.kind == K_READ});
        chk({pn, "_err"}, {31'd0, er}, {31'd0, it.kind == K_ERR});
        chk({pn, "_rdata"}, rd, held[p]);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            mon_port(0, "a", a_rvalid, a_err, a_rdata);
            mon_port(1, "b", b_rvalid, b_err, b_rdata);
        end
    end

    // Reference arbiter: owner 0=none, 1=A, 2=B; last = most recent tie winner/releaser.
    req_t pa = '0, pb = '0;
    logic do_rst = 1'b1;
    int   own = 0, last = 2, burst = 0;
    int   gseq [$];

    function automatic req_t mkreq(input logic we, input logic lock, input logic [7:0] addr,
                                   input logic [31:0] wd);
        req_t r;
        r.req = 1'b1; r.we = we; r.lock = lock; r.addr = addr; r.wdata = wd;
        return r;
    endfunction

    function automatic req_t rnd_req();
        logic [7:0] ad;
        ad = 8'($urandom_range(0, 63));
        if ($urandom_range(0, 7) != 0) ad[1:0] = 2'b00;
        return mkreq(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, ad, $urandom);
    endfunction

    task automatic model_cycle();
        int          win;
        req_t        x;
        logic        mis;
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] rd;
        item_t       it;
        win = 0;
        if (own == 0) begin
            if (pa.req && pb.req) win = (last == 1) ? 2 : 1;
            else if (pa.req) win = 1;
            else if (pb.req) win = 2;
        end else if (own == 1 && pa.req) win = 1;
        else if (own == 2 && pb.req) win = 2;
        x   = (win == 2) ? pb : pa;
        mis = (x.addr[1:0] != 2'b00);
        chk("a_gnt", {31'd0, a_gnt}, {31'd0, win == 1});
        chk("b_gnt", {31'd0, b_gnt}, {31'd0, win == 2});
        chk("mem_we", {31'd0, mem_we}, {31'd0, win != 0 && x.we && !mis});
        chk("mem_addr", {24'd0, mem_addr}, (win != 0) ? {24'd0, x.addr} : 32'd0);
        chk("mem_wdata", mem_wdata, (win != 0) ? x.wdata : 32'd0);
        b0 = x.addr; b1 = b0 + 8'd1; b2 = b0 + 8'd2; b3 = b0 + 8'd3;
        rd = {ref_mem[b0], ref_mem[b1], ref_mem[b2], ref_mem[b3]};
        if (win != 0 && x.we && !mis) begin
            ref_mem[b0] = x.wdata[31:24]; ref_mem[b1] = x.wdata[23:16];
            ref_mem[b2] = x.wdata[15:8];  ref_mem[b3] = x.wdata[7:0];
        end
        if (do_rst) begin
            q[0].delete(); q[1].delete();
            it.kind = K_RST; it.data = '0;
            q[0].push_back(it); q[1].push_back(it);
            own = 0; last = 2; burst = 0;
        end else begin
            if (win != 0 && (mis || !x.we)) begin
                it.kind = mis ? K_ERR : K_READ;
                it.data = mis ? 32'd0 : rd;
                q[win - 1].push_back(it);
            end
            if (own == 0) begin
                if (pa.req && pb.req) last = win;
                if (win != 0 && x.lock && MAXB > 1) begin own = win; burst = 1; end
            end else if (win == 0) begin
                last = own; own = 0;
            end else begin
                burst++;
                if (!x.lock || burst == MAXB) begin last = own; own = 0; end
            end
        end
        if (win != 0) gseq.push_back(win);
        if (win == 1) pa.req = 1'b0;
        if (win == 2) pb.req = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        rst = do_rst;
        a_req = pa.req; a_we = pa.we; a_lock = pa.lock; a_addr = pa.addr; a_wdata = pa.wdata;
        b_req = pb.req; b_we = pb.we; b_lock = pb.lock; b_addr = pb.addr; b_wdata = pb.wdata;
        #2;
        model_cycle();
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && (pa.req || pb.req); i++) step();
        chk("drain_timeout", {31'd0, pa.req || pb.req}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nb;
        logic [7:0] saved [4];
        int         diffs;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        held[0] = '0; held[1] = '0;
        load = 1'b1;
        @(negedge clk);
        #1 load = 1'b0;

        // Reset
        do_rst = 1'b1;
        step();
        mon_en = 1'b1;
        step();
        do_rst = 1'b0;
        step();

        // Write then read back on A
        pa = mkreq(1'b1, 1'b0, 8'h10, 32'hDEADBEEF);
        drain();
        pa = mkreq(1'b0, 1'b0, 8'h10, 32'h0);
        drain();
        step();
        chk("a_rvalid_after_read", {31'd0, a_rvalid}, 32'd1);
        chk("a_rdata_deadbeef", a_rdata, 32'hDEADBEEF);

        // Ties alternate: A,B then B,A
        gseq.delete();
        pa = mkreq(1'b0, 1'b0, 8'h20, 32'h0);
        pb = mkreq(1'b0, 1'b0, 8'h24, 32'h0);
        drain();
        pa = mkreq(1'b0, 1'b0, 8'h28, 32'h0);
        pb = mkreq(1'b0, 1'b0, 8'h2C, 32'h0);
        drain();
        chk("tie_n", gseq.size(), 4);
        chk("tie_0", gseq[0], 1);
        chk("tie_1", gseq[1], 2);
        chk("tie_2", gseq[2], 2);
        chk("tie_3", gseq[3], 1);

        // Locked B burst of 10 with A waiting: 8 B, then A, then B resumes
        gseq.delete();
        nb = 0;
        for (int i = 0; i < 60 && (nb < 10 || pa.req || pb.req); i++) begin
            if (!pb.req && nb < 10) begin
                pb = mkreq(1'b0, 1'b1, 8'(4 * nb), 32'h0);
                nb++;
            end
            if (i == 1) pa = mkreq(1'b0, 1'b0, 8'h30, 32'h0);
            step();
        end
        chk("burst_n", gseq.size(), 11);
        for (int i = 0; i < 8; i++) chk("burst_b", gseq[i], 2);
        chk("burst_a", gseq[8], 1);
        chk("burst_resume", gseq[9], 2);
        step();

        // Misaligned read and write on A
        pa = mkreq(1'b0, 1'b0, 8'h05, 32'h0);
        drain();
        step();
        chk("mis_err", {31'd0, a_err}, 32'd1);
        chk("mis_rvalid", {31'd0, a_rvalid}, 32'd0);
        for (int i = 0; i < 4; i++) saved[i] = mem[5 + i];
        pa = mkreq(1'b1, 1'b0, 8'h05, 32'hCAFEF00D);
        drain();
        step();
        for (int i = 0; i < 4; i++) chk("mis_mem", {24'd0, mem[5 + i]}, {24'd0, saved[i]});

        // Reset in the middle of a locked B burst
        for (int i = 0; i < 3; i++) begin
            pb = mkreq(1'b0, 1'b1, 8'(8'h40 + 8'(4 * i)), 32'h0);
            step();
        end
        pb = mkreq(1'b0, 1'b1, 8'h50, 32'h0);
        do_rst = 1'b1;
        step();
        do_rst = 1'b0;
        step();
        chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        chk("rst_b_rdata", b_rdata, 32'd0);
        chk("rst_outputs", {28'd0, a_gnt, b_gnt, mem_we, a_rvalid}, 32'd0);
        step();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            if (!pa.req && $urandom_range(0, 9) < 6) pa = rnd_req();
            if (!pb.req && $urandom_range(0, 9) < 6) pb = rnd_req();
            do_rst = ($urandom_range(0, 299) == 0);
            step();
        end
        do_rst = 1'b0;
        pa = '0; pb = '0;
        step();
        step();
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_final", diffs, 0);

        // ALIGN_CHECK=0 instance: wrap-around word at 0xFE
        @(posedge clk); #2 u_rst = 1'b0;
        @(posedge clk); #2;
        u_a_req = 1'b1; u_a_we = 1'b1; u_a_addr = 8'hFE; u_a_wdata = 32'h11223344;
        #2;
        chk("u_wr_gnt", {31'd0, u_a_gnt}, 32'd1);
        chk("u_wr_we", {31'd0, u_mem_we}, 32'd1);
        chk("u_wr_addr", {24'd0, u_mem_addr}, 32'hFE);
        @(posedge clk); #2 u_a_we = 1'b0;
        #2;
        chk("u_rd_gnt", {31'd0, u_a_gnt}, 32'd1);
        chk("u_rd_we", {31'd0, u_mem_we}, 32'd0);
        @(posedge clk); #1;
        chk("u_rvalid_fe", {31'd0, u_a_rvalid}, 32'd1);
        chk("u_rdata_fe", u_a_rdata, 32'h11223344);
        chk("u_byte00", {24'd0, mem0[0]}, 32'h33);
        chk("u_byteff", {24'd0, mem0[255]}, 32'h22);
        #1 u_a_addr = 8'h01;
        @(posedge clk); #1;
        chk("u_rvalid_01", {31'd0, u_a_rvalid}, 32'd1);
        chk("u_err_01", {31'd0, u_a_err}, 32'd0);
        chk("u_rdata_01", u_a_rdata, 32'h44000000);
        #1 u_a_req = 1'b0;
        @(posedge clk); #2;
        chk("u_rvalid_end", {31'd0, u_a_rvalid}, 32'd0);
        chk("u_b_idle", {29'd0, u_b_gnt, u_b_rvalid, u_b_err}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
